add_arbiter: RTL and testbench
==============================

# add_arbiter

Round-robin arbiter and sequencer that shares a single combinational `adder` instance among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester, registers its operands onto the shared adder, captures the `DATA_WD+1`-bit sum and returns it with the requester id on a valid/ready response channel. It sits between the requesting datapath blocks and the adder; the adder is external and connected through the `o_add_*`/`i_add_sum` ports.

## Interface
- `DATA_WD`, 16, operand width; the sum is `DATA_WD+1` bits.
- `NUM_REQ`, 4, number of requesters; must be ≥2. `ID_WD = $clog2(NUM_REQ)` (derived, localparam).
- `i_clk`  in  1  clock; all state on its rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_req_valid`  in  NUM_REQ  per-requester request valid.
- `o_req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `i_req_a`  in  NUM_REQ*DATA_WD  operand A, requester k at bits `[k*DATA_WD +: DATA_WD]`.
- `i_req_b`  in  NUM_REQ*DATA_WD  operand B, same packing.
- `o_add_a`  out  DATA_WD  registered operand A to the shared adder `i_a`.
- `o_add_b`  out  DATA_WD  registered operand B to the shared adder `i_b`.
- `i_add_sum`  in  DATA_WD+1  adder `o_sum`.
- `o_rsp_valid`  out  1  response valid.
- `o_rsp_id`  out  ID_WD  index of the requester that owns the response.
- `o_rsp_sum`  out  DATA_WD+1  registered sum.
- `i_rsp_ready`  in  1  response consumer accept.

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- **IDLE:**
  - Winner g = first k with `i_req_valid[k]`=1, searching k = ptr, ptr+1, … modulo NUM_REQ.
  - `o_req_ready[g]`=1 combinationally; all other ready bits are 0. No valid requester means all ready bits are 0 and the FSM stays in IDLE.
  - On handshake (`valid[g]` & `ready[g]`): latch `i_req_a`/`i_req_b` slice g into the operand registers, latch g into the id register, set ptr = (g+1) mod NUM_REQ, go to CALC.
- **CALC:** the operand registers drive `o_add_a`/`o_add_b`. Latch `i_add_sum` into the `o_rsp_sum` register, go to RESP. `o_req_ready`=0.
- **RESP:**
  - `o_rsp_valid`=1.
  - `o_rsp_sum` and `o_rsp_id` hold stable until `i_rsp_ready`=1.
  - On that edge, go to IDLE. `o_req_ready`=0.
- Arithmetic: the full `DATA_WD+1`-bit sum is passed through unmodified, so no overflow is lost. The arbiter does no arithmetic itself.
- `o_add_a`/`o_add_b` always reflect the operand registers, outside CALC as well. They change only on a handshake edge.
- Requesters must hold valid and data stable until ready. A valid dropped before grant is not served; there is no queuing.
- A valid that stays high through CALC/RESP is evaluated again in the next IDLE.
- `i_rsp_ready` outside RESP is ignored.

## Timing
- Reset (`i_rst_n`=0, asynchronous):
  - state=IDLE, ptr=0.
  - `o_add_a`=0, `o_add_b`=0, `o_rsp_sum`=0, `o_rsp_id`=0, `o_rsp_valid`=0.
  - `o_req_ready` is all 0 while reset is asserted.
  - Reset during CALC/RESP drops the transaction; no response is issued.
- Latency: request handshake at edge t; sum captured at edge t+1; `o_rsp_valid`=1 from t+1 to the response handshake edge.
- Minimum issue interval is 3 cycles (IDLE, CALC, RESP with `i_rsp_ready`=1). New grants are possible in the cycle after the response handshake.
- Backpressure: `o_rsp_valid` stays asserted with stable data for any number of `i_rsp_ready`=0 cycles. No new grant is made meanwhile.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0. Any requester waits at most NUM_REQ-1 other transactions.
- ptr wraps from NUM_REQ-1 to 0.

## Test plan
- **Single request:** requester 2, a=0x0003, b=0x0004, `i_rsp_ready`=1 → `o_req_ready`=4'b0100 in IDLE; response valid one cycle after the handshake, sum=0x00007, id=2.
- **Simultaneous requests:** all four valid from reset with a=k, b=0x0100 → responses in id order 0,1,2,3, sums 0x00100..0x00103, each 3 cycles apart.
- **Overflow:** a=0xFFFF, b=0xFFFF → `o_rsp_sum`=0x1FFFE. Also a=0xFFFF, b=0x0001 → 0x10000.
- **Backpressure:** `i_rsp_ready`=0 for 5 cycles in RESP → valid, id and sum stable for all 5 cycles; `o_req_ready` stays 0 while requester 1 is valid; requester 1 is granted in the IDLE cycle after release.
- **Fairness:** requesters 0 and 3 permanently valid → grant sequence 0,3,0,3; requester 0 is never granted twice in a row.
- **Reset mid-operation:** assert `i_rst_n`=0 during RESP → `o_rsp_valid`=0 immediately (asynchronously) and all outputs are 0. After release with requester 1 valid, the grant goes to 1 with ptr restarted at 0.

Source files
------------

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter that time-shares one external combinational adder among
// NUM_REQ requesters.
//
// Each transaction runs through three steps:
//   1. The winning request is accepted and its operands are registered onto the adder.
//   2. The adder result is captured.
//   3. The result is held on the response channel until the consumer accepts it.
//
// Ports:
//   i_clk, i_rst_n          clock; asynchronous active-low reset
//   i_req_valid/o_req_ready per-requester handshake (ready is one-hot or zero)
//   i_req_a/i_req_b         packed operands, requester k at [k*DATA_WD +: DATA_WD]
//   o_add_a/o_add_b         registered operands to the shared adder
//   i_add_sum               DATA_WD+1 bit sum from the shared adder
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_id/o_rsp_sum      owner of the response and its registered sum
module add_arbiter #(
  parameter int unsigned DATA_WD = 16,
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_WD = $clog2(NUM_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*DATA_WD-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_WD-1:0] i_req_b,
  output logic [DATA_WD-1:0]         o_add_a,
  output logic [DATA_WD-1:0]         o_add_b,
  input  logic [DATA_WD:0]           i_add_sum,
  output logic                       o_rsp_valid,
  output logic [ID_WD-1:0]           o_rsp_id,
  output logic [DATA_WD:0]           o_rsp_sum,
  input  logic                       i_rsp_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ID_WD-1:0]   ptr_q, ptr_d;
  logic [ID_WD-1:0]   id_q, id_d;
  logic [DATA_WD-1:0] a_q, a_d;
  logic [DATA_WD-1:0] b_q, b_d;
  logic [DATA_WD:0]   sum_q, sum_d;

  // Unpacked views of the operand buses so the winner can be selected by index.
  logic [DATA_WD-1:0] req_a_arr [NUM_REQ];
  logic [DATA_WD-1:0] req_b_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_a_arr[k] = i_req_a[k*DATA_WD +: DATA_WD];
    assign req_b_arr[k] = i_req_b[k*DATA_WD +: DATA_WD];
  end

  // Round-robin search starting at ptr_q.
  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_WD-1:0]   grant_id;
  logic               grant_found;
  logic [ID_WD:0]     cand;

  always_comb begin
    grant_oh    = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // One extra bit keeps ptr+i from overflowing before the modulo wrap.
      cand = {1'b0, ptr_q} + (ID_WD+1)'(i);
      if (cand >= (ID_WD+1)'(NUM_REQ)) begin
        cand = cand - (ID_WD+1)'(NUM_REQ);
      end
      if (!grant_found && i_req_valid[cand[ID_WD-1:0]]) begin
        grant_found                 = 1'b1;
        grant_id                    = cand[ID_WD-1:0];
        grant_oh[cand[ID_WD-1:0]]   = 1'b1;
      end
    end
  end

  // Ready is masked by reset so nothing looks accepted while reset is held.
  assign o_req_ready = (state_q == IDLE && i_rst_n) ? grant_oh : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d     = req_a_arr[grant_id];
          b_d     = req_b_arr[grant_id];
          id_d    = grant_id;
          ptr_d   = (grant_id == ID_WD'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = i_add_sum;
        state_d = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign o_add_a     = a_q;
  assign o_add_b     = b_q;
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_id    = id_q;
  assign o_rsp_sum   = sum_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: transaction-level model, per-cycle output compare,
// directed scenarios with literal expectations, then a randomized run.
module tb_add_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic [DW-1:0] add_a, add_b;
  logic [DW:0]   add_sum;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [DW:0]   rsp_sum;
  logic          rsp_ready = 1'b0;

  always #5 clk = ~clk;

  // External shared adder.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  add_arbiter #(.DATA_WD(DW), .NUM_REQ(NR)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .i_add_sum   (add_sum),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_sum   (rsp_sum),
    .i_rsp_ready (rsp_ready)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: one in-flight job, a flag saying its sum has been produced, and the
  // round-robin start position.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_ptr  = 0;
  int          m_id   = 0;
  logic [DW-1:0] m_a  = '0;
  logic [DW-1:0] m_b  = '0;
  logic [DW:0]   m_sum = '0;

  function automatic int m_winner();
    int k;
    if (!rst_n || m_busy) return -1;
    for (int i = 0; i < NR; i++) begin
      k = (m_ptr + i) % NR;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_ptr <= 0; m_id <= 0;
      m_a <= '0; m_b <= '0; m_sum <= '0;
    end else if (!m_busy) begin
      w = m_winner();
      if (w >= 0) begin
        m_a    <= req_a[w*DW +: DW];
        m_b    <= req_b[w*DW +: DW];
        m_id   <= w;
        m_ptr  <= (w + 1) % NR;
        m_busy <= 1'b1;
      end
    end else if (!m_done) begin
      m_sum  <= {1'b0, m_a} + {1'b0, m_b};
      m_done <= 1'b1;
    end else if (rsp_ready) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  // Logs: grants from the model (with DUT ready vector), responses from the DUT.
  int            cyc = 0;
  int            g_id[$];
  int            g_cyc[$];
  logic [NR-1:0] g_vec[$];
  int            r_id[$];
  int            r_cyc[$];
  logic [DW:0]   r_sum[$];

  always @(negedge clk) begin
    int w;
    logic [NR-1:0] er;
    w  = m_winner();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_done));
    check("rsp_id", 32'(rsp_id), m_id);
    check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
    check("add_a", 32'(add_a), 32'(m_a));
    check("add_b", 32'(add_b), 32'(m_b));
    if (w >= 0) begin
      g_id.push_back(w); g_cyc.push_back(cyc); g_vec.push_back(req_ready);
    end
    if (rsp_valid && rsp_ready) begin
      r_id.push_back(int'(rsp_id)); r_sum.push_back(rsp_sum); r_cyc.push_back(cyc);
    end
    cyc++;
  end

  logic [NR-1:0] keep = '0;
  bit            rnd  = 1'b0;

  task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[k]       = 1'b1;
    req_a[k*DW +: DW]  = a;
    req_b[k*DW +: DW]  = b;
  endtask

  task automatic new_rand_req(input int k);
    logic [DW-1:0] a, b;
    a = DW'($urandom);
    b = DW'($urandom);
    if ($urandom_range(0, 7) == 0) a = '1;
    if ($urandom_range(0, 7) == 0) b = '1;
    set_req(k, a, b);
  endtask

  // One clock: requesters drop (or refill) after a handshake, inputs change 1 after the edge.
  task automatic step();
    logic [NR-1:0] rdy;
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (req_valid[k] && rdy[k]) begin
        if (rnd) begin
          if ($urandom_range(0, 1) == 1) new_rand_req(k);
          else req_valid[k] = 1'b0;
        end else if (!keep[k]) begin
          req_valid[k] = 1'b0;
        end
      end else if (rnd && !req_valid[k] && $urandom_range(0, 2) == 0) begin
        new_rand_req(k);
      end
    end
    if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete(); g_vec.delete();
    r_id.delete(); r_sum.delete(); r_cyc.delete();
  endtask

  task automatic apply_reset();
    rnd = 1'b0; keep = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0;
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    #1;
    // Reset values.
    apply_reset();
    check("rst_sum", 32'(rsp_sum), 32'h0);
    check("rst_id", 32'(rsp_id), 32'h0);
    check("rst_add_a", 32'(add_a), 32'h0);
    check("rst_add_b", 32'(add_b), 32'h0);

    // Single request from requester 2.
    rsp_ready = 1'b1;
    set_req(2, 16'h0003, 16'h0004);
    run(6);
    check("single_ngrant", g_id.size(), 1);
    check("single_nrsp", r_id.size(), 1);
    if (g_id.size() >= 1) begin
      check("single_grant", g_id[0], 2);
      check("single_ready_vec", 32'(g_vec[0]), 32'h4);
    end
    if (r_id.size() >= 1 && g_id.size() >= 1) begin
      check("single_id", r_id[0], 2);
      check("single_sum", 32'(r_sum[0]), 32'h7);
      check("single_latency", r_cyc[0] - g_cyc[0], 2);
    end

    // All four requesting at once.
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < NR; k++) set_req(k, DW'(k), 16'h0100);
    run(16);
    check("simul_nrsp", r_id.size(), 4);
    for (int k = 0; k < r_id.size() && k < 4; k++) begin
      check("simul_id", r_id[k], k);
      check("simul_sum", 32'(r_sum[k]), 32'h100 + 32'(k));
      if (k > 0) check("simul_spacing", r_cyc[k] - r_cyc[k-1], 3);
    end

    // Carry out of the operand width.
    apply_reset();
    rsp_ready = 1'b1;
    set_req(0, 16'hFFFF, 16'hFFFF);
    run(5);
    set_req(1, 16'hFFFF, 16'h0001);
    run(5);
    check("ovf_nrsp", r_id.size(), 2);
    if (r_sum.size() >= 2) begin
      check("ovf_sum0", 32'(r_sum[0]), 32'h1FFFE);
      check("ovf_sum1", 32'(r_sum[1]), 32'h10000);
    end

    // Response backpressure.
    apply_reset();
    rsp_ready = 1'b0;
    set_req(0, 16'h0005, 16'h0006);
    run(3);
    set_req(1, 16'h0001, 16'h0002);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_id", 32'(rsp_id), 32'h0);
      check("bp_sum", 32'(rsp_sum), 32'hB);
      check("bp_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_release", 32'(rsp_valid), 32'h1);
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'h2);
    run(4);

    // Fairness with requesters 0 and 3 always valid.
    apply_reset();
    rsp_ready = 1'b1;
    keep = 4'b1001;
    set_req(0, 16'h0010, 16'h0001);
    set_req(3, 16'h0030, 16'h0003);
    run(14);
    check("fair_ngrant_ge4", 32'(g_id.size() >= 4), 32'h1);
    if (g_id.size() >= 4) begin
      check("fair_g0", g_id[0], 0);
      check("fair_g1", g_id[1], 3);
      check("fair_g2", g_id[2], 0);
      check("fair_g3", g_id[3], 3);
    end
    for (int i = 1; i < g_id.size(); i++) begin
      if (g_id[i] == 0) check("fair_prev_not0", g_id[i-1], 3);
    end

    // Reset during RESP.
    apply_reset();
    rsp_ready = 1'b1;
    set_req(1, 16'h0009, 16'h0009);
    run(4);
    rsp_ready = 1'b0;
    set_req(2, 16'h0007, 16'h0008);
    run(3);
    check("mid_in_resp", 32'(rsp_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(rsp_valid), 32'h0);
    check("mid_ready", 32'(req_ready), 32'h0);
    check("mid_sum", 32'(rsp_sum), 32'h0);
    check("mid_id", 32'(rsp_id), 32'h0);
    check("mid_add_a", 32'(add_a), 32'h0);
    check("mid_add_b", 32'(add_b), 32'h0);
    @(posedge clk); #1;
    req_valid = '0;
    set_req(1, 16'h0001, 16'h0001);
    set_req(3, 16'h0002, 16'h0002);
    clear_logs();
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    run(4);
    if (g_id.size() >= 1) begin
      check("mid_regrant", g_id[0], 1);
      check("mid_regrant_vec", 32'(g_vec[0]), 32'h2);
    end else begin
      check("mid_ngrant", g_id.size(), 1);
    end
    if (r_id.size() >= 1) begin
      check("mid_rsp_id", r_id[0], 1);
      check("mid_rsp_sum", 32'(r_sum[0]), 32'h2);
    end else begin
      check("mid_nrsp", r_id.size(), 1);
    end

    // Randomized traffic against the model.
    apply_reset();
    rnd = 1'b1;
    rsp_ready = 1'b1;
    run(3000);
    rnd = 1'b0;
    check("rand_activity", 32'(r_id.size() > 100), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
